// File: rtl/heartbeat_peak_detect_pkg.sv
// Shared types and constants for the heartbeat peak detector and its BPM divider.
package heartbeat_peak_detect_pkg;

    localparam int IVL_W = 10;
    localparam int DVD_W = 16;
    localparam int BPM_W = 8;

    typedef enum logic [1:0] {
        ST_ARMED,
        ST_TRACK,
        ST_REFRACT
    } hb_state_e;

    // Samples-per-minute numerator: bpm = bpm_const(FS) / interval.
    function automatic logic [DVD_W-1:0] bpm_const(input int fs);
        return DVD_W'(60 * fs);
    endfunction

endpackage

// File: rtl/heartbeat_peak_detect_if.sv
// Sample-in / beat-out bundle between the match filter, the detector and the display logic.
interface heartbeat_peak_detect_if #(
    parameter int DATA_W = 16
);
    import heartbeat_peak_detect_pkg::*;

    logic                     ready;
    logic signed [DATA_W-1:0] y;
    logic                     beat;
    logic [IVL_W-1:0]         interval;
    logic [BPM_W-1:0]         bpm;
    logic                     bpm_valid;
    logic signed [DATA_W-1:0] threshold;

    modport master (
        output ready, y,
        input  beat, interval, bpm, bpm_valid, threshold
    );

    modport slave (
        input  ready, y,
        output beat, interval, bpm, bpm_valid, threshold
    );

endinterface

// File: rtl/heartbeat_peak_detect_bpm_divider.sv
// Iterative restoring divider, one quotient bit per clock, quotient saturated to BPM_W bits.
module bpm_divider
    import heartbeat_peak_detect_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [IVL_W-1:0] divisor,
    output logic [BPM_W-1:0] quotient,
    output logic             done,
    output logic             busy
);

    localparam int                STEP_W    = $clog2(DVD_W);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(DVD_W - 1);

    logic [IVL_W-1:0]  rem;
    logic [DVD_W-1:0]  q;
    logic [IVL_W-1:0]  dvs;
    logic [STEP_W-1:0] step;

    logic [IVL_W:0]    r_sh;
    logic [IVL_W:0]    r_nx;
    logic              ge;
    logic [DVD_W-1:0]  q_nx;

    // q starts as the dividend and fills with quotient bits from the bottom.
    always_comb begin
        r_sh = {rem, q[DVD_W-1]};
        ge   = (r_sh >= {1'b0, dvs});
        r_nx = ge ? (r_sh - {1'b0, dvs}) : r_sh;
        q_nx = {q[DVD_W-2:0], ge};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            quotient <= '0;
            rem      <= '0;
            q        <= '0;
            dvs      <= '0;
            step     <= '0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                rem  <= r_nx[IVL_W-1:0];
                q    <= q_nx;
                step <= step + 1'b1;
                if (step == STEP_LAST) begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    step     <= '0;
                    quotient <= (|q_nx[DVD_W-1:BPM_W]) ? '1 : q_nx[BPM_W-1:0];
                end
            end else if (start) begin
                busy <= 1'b1;
                rem  <= '0;
                q    <= dividend;
                dvs  <= divisor;
                step <= '0;
            end
        end
    end

endmodule

// File: rtl/heartbeat_peak_detect.sv
// Adaptive-threshold peak detector with refractory lockout, inter-beat interval and BPM output.
module heartbeat_peak_detect
    import heartbeat_peak_detect_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int FS          = 250,
    parameter int REFRACT     = 50,
    parameter int MAX_GAP     = 500,
    parameter int DECAY_SHIFT = 6,
    parameter int MIN_THRESH  = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    heartbeat_peak_detect_if.slave hb
);

    localparam int                       RC_W    = $clog2(REFRACT);
    localparam logic signed [DATA_W-1:0] THR_MIN = DATA_W'(MIN_THRESH);
    localparam logic [IVL_W-1:0]         GAP_MAX = IVL_W'(MAX_GAP);
    localparam logic [RC_W-1:0]          RC_LAST = RC_W'(REFRACT - 1);
    localparam logic [DVD_W-1:0]         BPM_K   = bpm_const(FS);

    hb_state_e state, state_nx;

    logic signed [DATA_W-1:0] env;
    logic signed [DATA_W-1:0] cand;
    logic signed [DATA_W-1:0] env_half;
    logic signed [DATA_W-1:0] env_dec;
    logic signed [DATA_W-1:0] thr_nx;
    logic [IVL_W-1:0]         cnt;
    logic [IVL_W-1:0]         cnt_n;
    logic                     timeout;
    logic [RC_W-1:0]          rc;
    logic                     have_prev;

    logic                     declare;
    logic                     cand_ld;

    logic                     div_start;
    logic                     div_done;
    logic                     div_busy;
    logic [BPM_W-1:0]         div_q;

    always_comb begin
        env_half = env >>> 1;
        env_dec  = env - (env >>> DECAY_SHIFT);
        thr_nx   = (env_half > THR_MIN) ? env_half : THR_MIN;
        cnt_n    = (cnt >= GAP_MAX - 1'b1) ? GAP_MAX : cnt + 1'b1;
        timeout  = (cnt_n == GAP_MAX);
    end

    always_ff @(posedge clock) begin
        if (reset) state <= ST_ARMED;
        else       state <= state_nx;
    end

    // The sample that falls below the candidate marks the previous sample as the peak.
    always_comb begin
        state_nx = state;
        declare  = 1'b0;
        cand_ld  = 1'b0;
        if (hb.ready) begin
            unique case (state)
                ST_ARMED: begin
                    if (hb.y > hb.threshold) begin
                        state_nx = ST_TRACK;
                        cand_ld  = 1'b1;
                    end
                end
                ST_TRACK: begin
                    if (hb.y >= cand) begin
                        cand_ld = 1'b1;
                    end else begin
                        declare  = 1'b1;
                        state_nx = ST_REFRACT;
                    end
                end
                ST_REFRACT: begin
                    if (rc == RC_LAST) state_nx = ST_ARMED;
                end
                default: state_nx = ST_ARMED;
            endcase
        end
    end

    // A beat landing on the timeout sample still arms the next interval.
    always_ff @(posedge clock) begin
        if (reset) begin
            env          <= '0;
            cand         <= '0;
            cnt          <= '0;
            rc           <= '0;
            have_prev    <= 1'b0;
            hb.beat      <= 1'b0;
            hb.interval  <= '0;
            hb.threshold <= THR_MIN;
        end else begin
            hb.beat <= declare;
            if (hb.ready) begin
                if (hb.y > env)
                    env <= hb.y;
                else if (!env[DATA_W-1] && env != '0)
                    env <= env_dec;
                hb.threshold <= thr_nx;
                cnt          <= declare ? '0 : cnt_n;
                if (timeout) have_prev <= 1'b0;
                if (cand_ld) cand <= hb.y;
                if (state == ST_REFRACT && rc != RC_LAST) rc <= rc + 1'b1;
                if (declare) begin
                    hb.interval <= cnt_n;
                    rc          <= '0;
                    have_prev   <= 1'b1;
                end
            end
        end
    end

    assign div_start = declare && have_prev && !timeout && !div_busy;

    bpm_divider u_div (
        .clock    (clock),
        .reset    (reset),
        .start    (div_start),
        .dividend (BPM_K),
        .divisor  (cnt_n),
        .quotient (div_q),
        .done     (div_done),
        .busy     (div_busy)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            hb.bpm       <= '0;
            hb.bpm_valid <= 1'b0;
        end else begin
            hb.bpm_valid <= div_done;
            if (div_done) hb.bpm <= div_q;
            if (hb.ready && timeout) hb.bpm <= '0;
        end
    end

endmodule
